// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the I/D memory arbiter and its lane aligner.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_ERR    = 3'd3,
    ST_RESP   = 3'd4
  } arb_state_e;

  // The raw size encoding 2'b11 behaves as a full word.
  function automatic mem_size_e norm_size(input logic [1:0] raw);
    if (raw == 2'b11) return MEM_W;
    return mem_size_e'(raw);
  endfunction

  // Halves need an even address, words need a word-aligned address.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    case (size)
      MEM_H:   return off[0];
      MEM_W:   return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lane_align.sv
// Combinational sub-word lane handling: byte enables, store replication,
// load lane extraction with sign/zero extension, and misalignment flag.
module riscv_lane_align
  import riscv_mem_pkg::*;
(
  input  mem_size_e   size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and build enables/replicated data per access size.
  always_comb begin
    be         = 4'b1111;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    misaligned = is_misaligned(size, offset);
    half_sel   = offset[1] ? rdata[31:16] : rdata[15:0];
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    case (size)
      MEM_B: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      MEM_H: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port memory between the fetch (I) and load/store (D)
// ports, with a D-streak limit so a pending fetch cannot starve.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | arbitrate; combinational grant, fields latched on grant edge
// ST_BUSY_I | fetch in flight, m_req high until m_ack
// ST_BUSY_D | load/store in flight, m_req high until m_ack
// ST_ERR    | misaligned D access, no memory cycle; error response next
// ST_RESP   | rvalid pulse cycle, back to idle
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_e          state;
  logic [STREAK_W-1:0] streak;
  logic                lat_we;
  logic                lat_unsigned;
  mem_size_e           lat_size;
  logic [31:0]         lat_addr;
  logic [31:0]         lat_wdata;

  logic                idle;
  logic                d_win;
  logic [3:0]          lane_be;
  logic [31:0]         lane_wdata;
  logic [31:0]         lane_rdata;
  logic                lane_mis;

  // Grants are only offered in idle and never while reset is asserted.
  assign idle  = rst && (state == ST_IDLE);
  assign d_win = d_req && !(i_req && (streak == STREAK_MAX));
  assign d_gnt = idle && d_win;
  assign i_gnt = idle && i_req && !d_win;

  // Fetches are latched as unsigned words with zero store data, so the
  // aligner yields be=1111 for them without an extra mux.
  riscv_lane_align u_lane_align (
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .offset      (lat_addr[1:0]),
    .wdata       (lat_wdata),
    .rdata       (m_rdata),
    .be          (lane_be),
    .wdata_rep   (lane_wdata),
    .rdata_ext   (lane_rdata),
    .misaligned  (lane_mis)
  );

  // Memory-side fields come straight from the latched request, held at zero
  // outside a memory cycle.
  assign m_we    = m_req & lat_we;
  assign m_addr  = m_req ? {lat_addr[31:2], 2'b00} : 32'h0;
  assign m_be    = m_req ? lane_be : 4'b0000;
  assign m_wdata = m_req ? lane_wdata : 32'h0;

  // Arbiter FSM, streak counter, request latch and registered responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      streak       <= '0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= MEM_W;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
      m_req        <= 1'b0;
      i_rvalid     <= 1'b0;
      i_rdata      <= 32'h0;
      d_rvalid     <= 1'b0;
      d_rdata      <= 32'h0;
      d_err        <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;

      if (!i_req || i_gnt) begin
        streak <= '0;
      end else if (d_gnt && (streak != STREAK_MAX)) begin
        streak <= streak + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (d_gnt) begin
            lat_we       <= d_we;
            lat_unsigned <= d_unsigned;
            lat_size     <= norm_size(d_size);
            lat_addr     <= d_addr;
            lat_wdata    <= d_wdata;
            if (is_misaligned(norm_size(d_size), d_addr[1:0])) begin
              state <= ST_ERR;
            end else begin
              state <= ST_BUSY_D;
              m_req <= 1'b1;
            end
          end else if (i_gnt) begin
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b1;
            lat_size     <= MEM_W;
            lat_addr     <= i_addr;
            lat_wdata    <= 32'h0;
            state        <= ST_BUSY_I;
            m_req        <= 1'b1;
          end
        end
        ST_BUSY_I: begin
          if (m_ack) begin
            i_rdata  <= m_rdata;
            i_rvalid <= 1'b1;
            m_req    <= 1'b0;
            state    <= ST_RESP;
          end
        end
        ST_BUSY_D: begin
          if (m_ack) begin
            d_rdata  <= lat_we ? 32'h0 : lane_rdata;
            d_rvalid <= 1'b1;
            m_req    <= 1'b0;
            state    <= ST_RESP;
          end
        end
        ST_ERR: begin
          d_rdata  <= 32'h0;
          d_rvalid <= 1'b1;
          d_err    <= lane_mis;
          state    <= ST_IDLE;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a small behavioural memory.
module tb_riscv_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_size     (d_size),
    .d_unsigned (d_unsigned),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_be       (m_be),
    .m_wdata    (m_wdata),
    .m_ack      (m_ack),
    .m_rdata    (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: ack after ack_delay cycles of m_req, byte-enabled writes.
  logic [31:0] mem [0:255];
  int          ack_delay;
  int          wait_cnt;
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  assign m_ack   = m_req && (wait_cnt >= ack_delay);
  assign m_rdata = mem[m_addr[9:2]];

  always @(posedge clk) begin
    if (m_req && !m_ack) wait_cnt <= wait_cnt + 1;
    else                 wait_cnt <= 0;
    if (pre_we) begin
      mem[pre_idx] <= pre_val;
    end else if (m_req && m_ack && m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end
  end

  // Monitor: m_* stability while waiting, rvalid pulse width, rvalid count.
  logic        prev_m_req;
  logic        prev_m_we;
  logic [31:0] prev_m_addr;
  logic [3:0]  prev_m_be;
  logic [31:0] prev_m_wdata;
  logic        prev_d_rvalid;
  int          stab_err = 0;
  int          long_rv  = 0;
  int          d_rv_cnt = 0;

  always @(negedge clk) begin
    if (m_req && prev_m_req &&
        (m_we != prev_m_we || m_addr != prev_m_addr || m_be != prev_m_be || m_wdata != prev_m_wdata))
      stab_err <= stab_err + 1;
    if (d_rvalid && prev_d_rvalid) long_rv <= long_rv + 1;
    if (d_rvalid) d_rv_cnt <= d_rv_cnt + 1;
    prev_m_req    <= m_req;
    prev_m_we     <= m_we;
    prev_m_addr   <= m_addr;
    prev_m_be     <= m_be;
    prev_m_wdata  <= m_wdata;
    prev_d_rvalid <= d_rvalid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    @(posedge clk); #1;
    pre_we  = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the rvalid cycle.
  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic [3:0] be, output logic [31:0] mwd, output logic seen);
    int  n;
    bit  got;
    rdata = 32'hx; err = 1'bx; lat = 0; be = 4'h0; mwd = 32'h0; seen = 1'b0; got = 0;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size; d_unsigned = uns;
    #1;
    n = 0;
    while (!d_gnt && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    if (!d_gnt) begin
      check("d_gnt_timeout", 32'd0, 32'd1);
      d_req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    d_req = 1'b0; d_we = ~we; d_addr = ~addr; d_wdata = ~wdata; d_size = ~size; d_unsigned = ~uns;
    lat = 1;
    while (lat < 20) begin
      if (m_req && !seen) begin
        seen = 1'b1; be = m_be; mwd = m_wdata;
      end
      if (d_rvalid) begin
        got = 1; rdata = d_rdata; err = d_err;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!got) check("d_rvalid_timeout", 32'd0, 32'd1);
  endtask

  task automatic i_access(input logic [31:0] addr, output logic [31:0] rdata, output int lat,
                          output logic [3:0] be, output logic [31:0] maddr);
    int n;
    bit got;
    rdata = 32'hx; lat = 0; be = 4'h0; maddr = 32'h0; got = 0;
    i_req = 1'b1; i_addr = addr;
    #1;
    n = 0;
    while (!i_gnt && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    if (!i_gnt) begin
      check("i_gnt_timeout", 32'd0, 32'd1);
      i_req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    i_req = 1'b0; i_addr = ~addr;
    lat = 1;
    while (lat < 20) begin
      if (m_req) begin be = m_be; maddr = m_addr; end
      if (i_rvalid) begin got = 1; rdata = i_rdata; break; end
      @(posedge clk); #1;
      lat++;
    end
    if (!got) check("i_rvalid_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] ld_addr [6] = '{32'h100, 32'h102, 32'h102, 32'h103, 32'h101, 32'h100};
  logic [1:0]  ld_size [6] = '{2'b01,   2'b01,   2'b01,   2'b00,   2'b00,   2'b10};
  logic        ld_uns  [6] = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
  logic [31:0] ld_exp  [6] = '{32'hffffc0de, 32'hffffdead, 32'h0000dead,
                               32'hffffffde, 32'h000000c0, 32'hdeadc0de};
  logic [3:0]  ld_be   [6] = '{4'b0011, 4'b1100, 4'b1100, 4'b1000, 4'b0010, 4'b1111};

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic        seen;
    logic [31:0] maddr;
    logic [9:0]  seq;
    int          ng, cyc, last, gap_err, both, rv0, n;

    rst = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0;
    d_wdata = 32'h0; d_size = 2'b00; d_unsigned = 1'b0; ack_delay = 0; wait_cnt = 0;
    pre_we = 1'b0; pre_idx = 8'h0; pre_val = 32'h0;

    // Reset state, with a fetch request pending that must not be granted.
    i_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_req", {31'd0, m_req}, 32'd0);
    check("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    check("rst_flags", {24'd0, i_rvalid, d_rvalid, d_err, m_we, m_be}, 32'd0);
    check("rst_rdata", d_rdata | i_rdata, 32'd0);
    i_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    preload(8'h40, 32'hdeadc0de);
    preload(8'h41, 32'h00112233);

    // Loads with lane extraction, zero-wait memory.
    for (int k = 0; k < 6; k++) begin
      d_access(1'b0, ld_addr[k], 32'h0, ld_size[k], ld_uns[k], rd, er, lat, be, mwd, seen);
      check($sformatf("load%0d_data", k), rd, ld_exp[k]);
      check($sformatf("load%0d_lat", k), lat, 32'd2);
      check($sformatf("load%0d_be", k), {28'd0, be}, {28'd0, ld_be[k]});
    end
    d_access(1'b0, 32'h100, 32'h0, 2'b11, 1'b0, rd, er, lat, be, mwd, seen);
    check("load_size11_data", rd, 32'hdeadc0de);
    check("load_size11_be", {28'd0, be}, 32'hf);

    // Stores with replication.
    preload(8'h40, 32'hdeadbeef);
    d_access(1'b1, 32'h101, 32'h12, 2'b00, 1'b0, rd, er, lat, be, mwd, seen);
    check("sb_be", {28'd0, be}, 32'b0010);
    check("sb_wdata", mwd, 32'h12121212);
    check("sb_rdata", rd, 32'h0);
    check("sb_err", {31'd0, er}, 32'd0);
    check("sb_mem", mem[8'h40], 32'hdead12ef);
    d_access(1'b1, 32'h102, 32'hc001, 2'b01, 1'b0, rd, er, lat, be, mwd, seen);
    check("sh_be", {28'd0, be}, 32'b1100);
    check("sh_wdata", mwd, 32'hc001c001);
    check("sh_mem", mem[8'h40], 32'hc00112ef);

    // Misaligned accesses never reach memory.
    d_access(1'b0, 32'h101, 32'h0, 2'b01, 1'b0, rd, er, lat, be, mwd, seen);
    check("mis_lh_mreq", {31'd0, seen}, 32'd0);
    check("mis_lh_err", {31'd0, er}, 32'd1);
    check("mis_lh_rdata", rd, 32'h0);
    check("mis_lh_lat", lat, 32'd2);
    d_access(1'b1, 32'h102, 32'h55, 2'b10, 1'b0, rd, er, lat, be, mwd, seen);
    check("mis_sw_mreq", {31'd0, seen}, 32'd0);
    check("mis_sw_err", {31'd0, er}, 32'd1);
    check("mis_sw_lat", lat, 32'd2);
    check("mis_sw_mem", mem[8'h40], 32'hc00112ef);

    // Fetch: low address bits are dropped.
    i_access(32'h106, rd, lat, be, maddr);
    check("ifetch_data", rd, 32'h00112233);
    check("ifetch_lat", lat, 32'd2);
    check("ifetch_be", {28'd0, be}, 32'hf);
    check("ifetch_addr", maddr, 32'h104);

    // Wait states: five extra cycles before ack.
    ack_delay = 5;
    d_access(1'b1, 32'h100, 32'ha5a5a5a5, 2'b10, 1'b0, rd, er, lat, be, mwd, seen);
    check("wait_lat", lat, 32'd7);
    check("wait_wdata", mwd, 32'ha5a5a5a5);
    check("wait_stable", stab_err, 32'd0);
    @(posedge clk); #1;
    check("wait_rvalid_single", {31'd0, d_rvalid}, 32'd0);
    check("wait_mem", mem[8'h40], 32'ha5a5a5a5);
    check("rvalid_width", long_rv, 32'd0);
    ack_delay = 0;

    // Contention: both requests held high.
    d_we = 1'b0; d_addr = 32'h100; d_size = 2'b10; d_unsigned = 1'b0;
    d_req = 1'b1; i_req = 1'b1; i_addr = 32'h104;
    seq = '0; ng = 0; cyc = 0; last = 0; gap_err = 0; both = 0;
    while (ng < 10 && cyc < 60) begin
      #1;
      if (d_gnt && i_gnt) both++;
      if (d_gnt || i_gnt) begin
        seq = {seq[8:0], i_gnt};
        if (ng > 0 && cyc - last != 3) gap_err++;
        last = cyc;
        ng++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_req = 1'b0;
    check("cont_order", {22'd0, seq}, 32'h021);
    check("cont_count", ng, 32'd10);
    check("cont_gap", gap_err, 32'd0);
    check("cont_both", both, 32'd0);

    // D alone: one grant every three cycles.
    ng = 0; cyc = 0; last = 0; gap_err = 0; n = 0;
    while (ng < 4 && cyc < 40) begin
      #1;
      if (i_gnt) n++;
      if (d_gnt) begin
        if (ng > 0 && cyc - last != 3) gap_err++;
        last = cyc;
        ng++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    d_req = 1'b0;
    check("donly_count", ng, 32'd4);
    check("donly_gap", gap_err, 32'd0);
    check("donly_no_i", n, 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of a D access.
    ack_delay = 5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_size = 2'b10;
    #1;
    n = 0;
    while (!d_gnt && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check("rstmid_gnt", {31'd0, d_gnt}, 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    check("rstmid_busy", {31'd0, m_req}, 32'd1);
    rv0 = d_rv_cnt;
    rst = 1'b0;
    #1;
    check("rstmid_m_req", {31'd0, m_req}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    ack_delay = 0;
    repeat (6) @(posedge clk);
    #1;
    check("rstmid_no_rvalid", d_rv_cnt - rv0, 32'd0);
    i_access(32'h104, rd, lat, be, maddr);
    check("rstmid_fetch", rd, 32'h00112233);
    check("rstmid_fetch_lat", lat, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
